// File: rtl/lat_ram_request_queue.sv
// Request FIFO feeding a single-outstanding latency-RAM issuer (IDLE/ISSUE/GAP).
// Optional ISSUE-state watchdog enabled by defining LAT_RAM_REQUEST_TIMEOUT_EN.
module lat_ram_request_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        ram_load,
  output logic        ram_save,
  output logic [15:0] ram_address,
  output logic [15:0] ram_in,
  input  logic        ram_ready,
  input  logic [15:0] ram_out,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("lat_ram_request_queue: DEPTH must be a power of two in 2..16 and TIMEOUT >= 1");
  end

  logic [32:0]   fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic          ram_load_q, ram_load_d, ram_save_q, ram_save_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   ram_address_q, ram_address_d, ram_in_q, ram_in_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          push, pop;
  logic [32:0]   head;

`ifdef LAT_RAM_REQUEST_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_err_q, timeout_err_d;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Registered count only: a full FIFO refuses a push even while popping.
  assign req_ready   = !rst && (count_q < CW'(DEPTH));
  assign push        = req_valid && req_ready;
  assign pop         = (state_q == IDLE) && (count_q != '0);
  assign head        = fifo_q[rd_ptr_q];
  assign busy        = (count_q != '0) || (state_q != IDLE);
  assign ram_load    = ram_load_q;
  assign ram_save    = ram_save_q;
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {req_write, req_addr, req_data};
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    ram_load_d    = ram_load_q;
    ram_save_d    = ram_save_q;
    ram_address_d = ram_address_q;
    ram_in_d      = ram_in_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
`ifdef LAT_RAM_REQUEST_TIMEOUT_EN
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d       = ISSUE;
          ram_address_d = head[31:16];
          ram_in_d      = head[15:0];
          ram_save_d    = head[32];
          ram_load_d    = !head[32];
`ifdef LAT_RAM_REQUEST_TIMEOUT_EN
          timer_d       = '0;
`endif
        end
      end
      ISSUE: begin
        if (ram_ready) begin
          state_d    = GAP;
          ram_load_d = 1'b0;
          ram_save_d = 1'b0;
          if (ram_load_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = ram_out;
          end
        end
`ifdef LAT_RAM_REQUEST_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d       = GAP;
          ram_load_d    = 1'b0;
          ram_save_d    = 1'b0;
          timeout_err_d = 1'b1;
          if (ram_load_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 16'hFFFF;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      ram_load_q    <= 1'b0;
      ram_save_q    <= 1'b0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
`ifdef LAT_RAM_REQUEST_TIMEOUT_EN
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      ram_load_q    <= ram_load_d;
      ram_save_q    <= ram_save_d;
      ram_address_q <= ram_address_d;
      ram_in_q      <= ram_in_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
`ifdef LAT_RAM_REQUEST_TIMEOUT_EN
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_lat_ram_request_queue.sv
// Directed bench for lat_ram_request_queue with a small latency-RAM model.
// Timeout scenario is exercised when LAT_RAM_REQUEST_TIMEOUT_EN is defined.
module tb_lat_ram_request_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = '0, req_data = '0;
  logic        req_ready, rsp_valid, ram_load, ram_save, busy, timeout_err;
  logic [15:0] rsp_data, ram_address, ram_in;
  logic        ram_ready = 1'b0;
  logic [15:0] ram_out = '0;

  always #5 clk = ~clk;

  lat_ram_request_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_load(ram_load), .ram_save(ram_save), .ram_address(ram_address),
    .ram_in(ram_in), .ram_ready(ram_ready), .ram_out(ram_out),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RAM model: completes after lat strobe cycles unless hold is set.
  logic        hold = 1'b0;
  int          lat  = 3;
  int          cyc  = 0;
  logic [15:0] ram_mem [16] = '{default: '0};

  always @(posedge clk) begin
    #1;
    if (ram_load || ram_save) begin
      cyc++;
      if (!hold && cyc >= lat) begin
        ram_ready = 1'b1;
        if (ram_save) ram_mem[ram_address[3:0]] = ram_in;
        else          ram_out = ram_mem[ram_address[3:0]];
      end else begin
        ram_ready = 1'b0;
      end
    end else begin
      cyc       = 0;
      ram_ready = 1'b0;
    end
  end

  int          rsp_cnt     = 0;
  int          gap_err     = 0;
  int          overlap_err = 0;
  logic        last_done   = 1'b0;
  logic [15:0] done_q [$];

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (ram_load && ram_save) overlap_err++;
    if (last_done && (ram_load || ram_save)) gap_err++;
    last_done = ram_ready && (ram_load || ram_save);
    if (last_done) done_q.push_back(ram_address);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_req(input logic w, input logic [15:0] a, input logic [15:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) check_eq("push_accept", req_ready, 1);
    @(posedge clk);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, rsp_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 500) begin
      tick();
      n++;
    end
    check_eq(tag, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    tick(); tick();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_load", ram_load, 0);
    check_eq("rst_save", ram_save, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_ram_address", ram_address, 0);
    check_eq("rst_ram_in", ram_in, 0);
    check_eq("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_req_ready", req_ready, 1);

    // Write, latency 3: strobe two cycles after the push, high 3 cycles.
    lat = 3;
    r0  = rsp_cnt;
    push_req(1'b1, 16'h0000, 16'h0001);
    check_eq("wr_save_n1", ram_save, 0);
    check_eq("wr_busy_n1", busy, 1);
    tick();
    check_eq("wr_save_n2", ram_save, 1);
    check_eq("wr_load_n2", ram_load, 0);
    check_eq("wr_addr", ram_address, 16'h0000);
    check_eq("wr_data", ram_in, 16'h0001);
    tick();
    check_eq("wr_save_n3", ram_save, 1);
    tick();
    check_eq("wr_save_n4", ram_save, 1);
    tick();
    check_eq("wr_save_gap", ram_save, 0);
    check_eq("wr_no_rsp", rsp_valid, 0);
    tick();
    check_eq("wr_idle", busy, 0);
    check_eq("wr_mem", ram_mem[0], 16'h0001);
    check_eq("wr_rsp_cnt", rsp_cnt, r0);

    // Read back addr 0 with latency 3.
    r0 = rsp_cnt;
    push_req(1'b0, 16'h0000, 16'h0000);
    tick();
    check_eq("rd_load", ram_load, 1);
    check_eq("rd_save", ram_save, 0);
    tick(); tick(); tick();
    check_eq("rd_rsp_valid", rsp_valid, 1);
    check_eq("rd_rsp_data", rsp_data, 16'h0001);
    check_eq("rd_load_gap", ram_load, 0);
    tick();
    check_eq("rd_rsp_pulse", rsp_valid, 0);
    check_eq("rd_rsp_hold", rsp_data, 16'h0001);
    check_eq("rd_rsp_cnt", rsp_cnt, r0 + 1);

    // Write then read the same address.
    lat = 1;
    push_req(1'b1, 16'h0001, 16'h0002);
    push_req(1'b0, 16'h0001, 16'h0000);
    wait_rsp("wr_rd_rsp_seen");
    check_eq("wr_rd_data", rsp_data, 16'h0002);
    wait_idle("wr_rd_idle");

    // One in flight stalled, four queued fill the FIFO; release drains in order.
    done_q.delete();
    hold = 1'b1;
    lat  = 2;
    push_req(1'b1, 16'h0004, 16'h0A04);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_ready", req_ready, 1);
      push_req(1'b1, 16'(5 + i), 16'(16'h0A05 + i));
    end
    check_eq("full_ready", req_ready, 0);
    repeat (4) tick();
    check_eq("full_ready_hold", req_ready, 0);
    check_eq("full_save", ram_save, 1);
    check_eq("full_addr", ram_address, 16'h0004);
    hold = 1'b0;
    wait_idle("drain_idle");
    check_eq("drain_count", done_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < done_q.size()) check_eq("drain_order", done_q[i], 16'(4 + i));
    end
    check_eq("drain_mem8", ram_mem[8], 16'h0A08);
    check_eq("gap_err", gap_err, 0);
    check_eq("overlap_err", overlap_err, 0);

    // Reset during ISSUE with two queued.
    hold = 1'b1;
    push_req(1'b1, 16'h0009, 16'h0B09);
    push_req(1'b1, 16'h000A, 16'h0B0A);
    push_req(1'b1, 16'h000B, 16'h0B0B);
    check_eq("mid_save", ram_save, 1);
    r0  = rsp_cnt;
    rst = 1'b1;
    @(posedge clk);
    tick();
    check_eq("mid_rst_save", ram_save, 0);
    check_eq("mid_rst_load", ram_load, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_ready", req_ready, 0);
    check_eq("mid_rst_addr", ram_address, 0);
    rst  = 1'b0;
    hold = 1'b0;
    repeat (5) tick();
    check_eq("mid_post_busy", busy, 0);
    check_eq("mid_post_rsp", rsp_cnt, r0);
    check_eq("mid_post_mem9", ram_mem[9], 16'h0000);
    check_eq("mid_post_memA", ram_mem[10], 16'h0000);

`ifdef LAT_RAM_REQUEST_TIMEOUT_EN
    hold = 1'b1;
    push_req(1'b0, 16'h0003, 16'h0000);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("to_load_hi", ram_load, 1);
      tick();
    end
    check_eq("to_load_lo", ram_load, 0);
    check_eq("to_rsp_valid", rsp_valid, 1);
    check_eq("to_rsp_data", rsp_data, 16'hFFFF);
    check_eq("to_err", timeout_err, 1);
    tick();
    check_eq("to_rsp_pulse", rsp_valid, 0);
    hold = 1'b0;
    repeat (3) tick();
    check_eq("to_err_sticky", timeout_err, 1);
    check_eq("to_busy", busy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_eq("to_err_cleared", timeout_err, 0);
`else
    hold = 1'b1;
    push_req(1'b0, 16'h0003, 16'h0000);
    repeat (20) tick();
    check_eq("nto_load_hi", ram_load, 1);
    check_eq("nto_err", timeout_err, 0);
    check_eq("nto_no_rsp", rsp_valid, 0);
    hold = 1'b0;
    wait_rsp("nto_rsp_seen");
    check_eq("nto_rsp_data", rsp_data, 16'h0000);
    wait_idle("nto_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
